// File: rtl/dsp_pwr_pkg.sv
// dsp_pwr_pkg: shared types and helpers for the power-measurement stimulus path.
//   state_e    - toggle_rate_monitor FSM encoding
//   RATE_MAX   - upper clamp for programmed toggle percentages
//   aw_f/tw_f  - result counter widths for a given window and bus width
package dsp_pwr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRIME   = 3'd1,
    ST_MEASURE = 3'd2,
    ST_CHECK   = 3'd3,
    ST_REPORT  = 3'd4
  } state_e;

  localparam logic [6:0] RATE_MAX = 7'd100;

  // Width needed to count active cycles 0..window.
  function automatic int aw_f(input int window);
    return $clog2(window + 1);
  endfunction

  // Width needed to count every bit flipping on every window cycle.
  function automatic int tw_f(input int data_w, input int window);
    return $clog2(data_w * window + 1);
  endfunction

  function automatic logic [6:0] clamp_rate(input logic [6:0] rate);
    return (rate > RATE_MAX) ? RATE_MAX : rate;
  endfunction

endpackage

// File: rtl/popcount_tree.sv
// popcount_tree: combinational population count built as a balanced adder tree.
//   din_i [DATA_W]            - vector to count
//   cnt_o [clog2(DATA_W+1)]   - number of ones in din_i
// Recurses on halves of the input until single bits remain.
module popcount_tree #(
  parameter  int DATA_W = 48,
  localparam int CW     = $clog2(DATA_W + 1)
) (
  input  logic [DATA_W-1:0] din_i,
  output logic [CW-1:0]     cnt_o
);

  if (DATA_W == 1) begin : g_leaf
    assign cnt_o = din_i;
  end else begin : g_split
    localparam int LO  = DATA_W / 2;
    localparam int HI  = DATA_W - LO;
    localparam int LCW = $clog2(LO + 1);
    localparam int HCW = $clog2(HI + 1);

    logic [LCW-1:0] lo_cnt;
    logic [HCW-1:0] hi_cnt;

    popcount_tree #(.DATA_W(LO)) u_lo (
      .din_i (din_i[LO-1:0]),
      .cnt_o (lo_cnt)
    );

    popcount_tree #(.DATA_W(HI)) u_hi (
      .din_i (din_i[DATA_W-1:LO]),
      .cnt_o (hi_cnt)
    );

    assign cnt_o = CW'(lo_cnt) + CW'(hi_cnt);
  end

endmodule

// File: rtl/toggle_rate_monitor.sv
// toggle_rate_monitor: measures switching activity on din over WINDOW cycles and
// checks it against the programmed toggle percentage (within TOL points).
//   clk, rst_n              - clock, async active-low reset
//   start, toggle_rate      - measurement request and expected percentage
//   din                     - monitored bus (clk domain)
//   busy                    - high whenever not IDLE
//   res_valid / res_ready   - result handshake
//   active_cycles           - window cycles where din changed
//   bit_toggles             - total bit flips over the window
//   pass, err_sticky        - result verdict and sticky failure flag
//
// state   | meaning
// IDLE    | wait for start, results hold previous values
// PRIME   | capture first din sample, load window counter
// MEASURE | accumulate activity for WINDOW cycles
// CHECK   | compare measured rate against expected rate
// REPORT  | present result until consumer accepts it
module toggle_rate_monitor
  import dsp_pwr_pkg::*;
#(
  parameter  int DATA_W = 48,
  parameter  int WINDOW = 100,
  parameter  int TOL    = 2,
  localparam int AW     = aw_f(WINDOW),
  localparam int TW     = tw_f(DATA_W, WINDOW)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [6:0]        toggle_rate,
  input  logic [DATA_W-1:0] din,
  output logic              busy,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [AW-1:0]     active_cycles,
  output logic [TW-1:0]     bit_toggles,
  output logic              pass,
  output logic              err_sticky
);

  localparam int          PCW      = $clog2(DATA_W + 1);
  localparam int          MW       = AW + 7;
  localparam int unsigned TOL_SPAN = TOL * WINDOW;

  state_e            state_q;
  logic [DATA_W-1:0] din_prev_q;
  logic [6:0]        exp_q;
  logic [AW-1:0]     win_cnt_q;
  logic              busy_q;
  logic              res_valid_q;
  logic [AW-1:0]     active_q;
  logic [TW-1:0]     bits_q;
  logic              pass_q;
  logic              err_q;

  logic [DATA_W-1:0] diff_d;
  logic [PCW-1:0]    pc_d;
  logic [MW-1:0]     meas_d;
  logic [MW-1:0]     expd_d;
  logic [MW-1:0]     dev_d;
  logic              pass_d;

  assign diff_d = din ^ din_prev_q;

  popcount_tree #(.DATA_W(DATA_W)) u_popcount (
    .din_i (diff_d),
    .cnt_o (pc_d)
  );

  // Both sides are scaled to "percent x WINDOW" so no division is needed.
  assign meas_d = MW'(active_q) * MW'(100);
  assign expd_d = MW'(exp_q) * MW'(WINDOW);
  assign dev_d  = (meas_d >= expd_d) ? (meas_d - expd_d) : (expd_d - meas_d);
  assign pass_d = (32'(dev_d) <= TOL_SPAN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      din_prev_q  <= '0;
      exp_q       <= '0;
      win_cnt_q   <= '0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      active_q    <= '0;
      bits_q      <= '0;
      pass_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            exp_q    <= clamp_rate(toggle_rate);
            active_q <= '0;
            bits_q   <= '0;
            busy_q   <= 1'b1;
            state_q  <= ST_PRIME;
          end
        end
        ST_PRIME: begin
          din_prev_q <= din;
          win_cnt_q  <= AW'(WINDOW - 1);
          state_q    <= ST_MEASURE;
        end
        ST_MEASURE: begin
          if (diff_d != '0) active_q <= active_q + AW'(1);
          bits_q     <= bits_q + TW'(pc_d);
          din_prev_q <= din;
          // Down-counter terminal count marks the last window sample.
          if (win_cnt_q == '0) state_q <= ST_CHECK;
          else                 win_cnt_q <= win_cnt_q - AW'(1);
        end
        ST_CHECK: begin
          pass_q      <= pass_d;
          if (!pass_d) err_q <= 1'b1;
          res_valid_q <= 1'b1;
          state_q     <= ST_REPORT;
        end
        ST_REPORT: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          busy_q      <= 1'b0;
          res_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign res_valid     = res_valid_q;
  assign active_cycles = active_q;
  assign bit_toggles   = bits_q;
  assign pass          = pass_q;
  assign err_sticky    = err_q;

endmodule
